// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I main controller. Control outputs are decoded from the registered
// state; FETCH and MEMWRITE also qualify their strobes with the memory handshake.
module mc_ctrl_fsm #(
  parameter bit MEM_WAIT      = 1'b1,
  parameter bit SUPPORT_UPPER = 1'b1,
  parameter bit HALT_ON_ILL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       retire,
  output logic       illegal,
  output logic       halted,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXEC_I   = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t state;
  state_t dec_st;
  logic   dec_ill;
  logic   rdy;

  // Without wait states the memory is assumed to answer in the same cycle.
  assign rdy       = !MEM_WAIT || mem_ready;
  assign state_dbg = state;

  always_comb begin
    dec_st  = S_FETCH;
    dec_ill = 1'b0;
    case (op)
      OP_LW, OP_SW: dec_st = S_MEMADR;
      OP_R:         dec_st = S_EXEC_R;
      OP_I:         dec_st = S_EXEC_I;
      OP_JAL:       dec_st = S_JAL;
      OP_JALR:      dec_st = S_JALR_ADR;
      OP_BR: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_ill = 1'b1;
        else                                      dec_st  = S_BRANCH;
      end
      OP_LUI: begin
        if (SUPPORT_UPPER) dec_st  = S_LUI;
        else               dec_ill = 1'b1;
      end
      OP_AUIPC: begin
        if (SUPPORT_UPPER) dec_st  = S_AUIPC;
        else               dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (rdy) state <= S_DECODE;
        S_DECODE: begin
          if (dec_ill) begin
            illegal <= 1'b1;
            state   <= HALT_ON_ILL ? S_HALT : S_FETCH;
          end else begin
            state   <= dec_st;
          end
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (rdy) state <= S_MEMWB;
        S_MEMWRITE: if (rdy) state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_JAL, S_JALR, S_LUI, S_AUIPC: state <= S_ALUWB;
        S_JALR_ADR: state <= S_JALR;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_SW:            ImmSrc = 3'b001;
      OP_BR:            ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        PCUpdate  = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR, S_JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        retire   = rdy;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      // Link value PC+4 is formed from OldPC while the target goes into PC.
      S_JAL, S_JALR: begin
        PCUpdate = 1'b1;
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
      end
      S_BRANCH: begin
        Branch  = 1'b1;
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        retire  = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Reset holds the selects at FETCH values but must not strobe anything.
    if (!rst) begin
      PCUpdate = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: three parameter variants share stimulus; a per-cycle vector table
// feeds a scoreboard checked on the falling edge, plus a hand-written mid-instruction reset.
module tb_mc_ctrl_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011, II = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b0000000;

  typedef struct packed {
    logic       pcu, br, adr, mrd, mwr, irw, rw;
    logic [1:0] res, a, b, aop;
    logic [2:0] imm;
    logic       ret, ill, hlt;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    int         dut;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       rdy;
    logic [3:0] st;
    logic       ill;
    string      nm;
  } vec_t;

  typedef struct {
    int    dut;
    obs_t  exp;
    string nm;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       rdy;
  obs_t       obs [3];

  int   nvec = 0;
  int   nbad = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: defaults; dut1: illegal returns to FETCH; dut2: no upper ops, no wait states
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit MW = (g != 2);
    localparam bit SU = (g != 2);
    localparam bit HI = (g != 1);
    logic       pcu, br, adr, mrd, mwr, irw, rw, ret, ill, hlt;
    logic [1:0] res, a, b, aop;
    logic [2:0] imm;
    logic [3:0] st;
    mc_ctrl_fsm #(.MEM_WAIT(MW), .SUPPORT_UPPER(SU), .HALT_ON_ILL(HI)) u_dut (
      .clk(clk), .rst(rst), .op(op), .funct3(f3), .mem_ready(rdy),
      .PCUpdate(pcu), .Branch(br), .AdrSrc(adr), .MemRead(mrd), .MemWrite(mwr),
      .IRWrite(irw), .RegWrite(rw), .ResultSrc(res), .ALUSrcA(a), .ALUSrcB(b),
      .ALUOp(aop), .ImmSrc(imm), .retire(ret), .illegal(ill), .halted(hlt),
      .state_dbg(st)
    );
    assign obs[g] = {pcu, br, adr, mrd, mwr, irw, rw, res, a, b, aop, imm, ret, ill, hlt, st};
  end

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      SW:         return 3'b001;
      BR:         return 3'b010;
      JAL:        return 3'b011;
      LUI, AUIPC: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Output table per state, written from the controller's state listing.
  function automatic obs_t expect_of(input vec_t v);
    obs_t o;
    logic re;
    o     = '0;
    re    = v.rdy || (v.dut == 2);
    o.st  = v.st;
    o.ill = v.ill;
    o.imm = imm_of(v.op);
    case (v.st)
      4'd0:  begin o.mrd = 1; o.b = 2'b10; o.res = 2'b10; o.irw = re; o.pcu = re; end
      4'd1:  begin o.a = 2'b01; o.b = 2'b01; end
      4'd2:  begin o.a = 2'b10; o.b = 2'b01; end
      4'd3:  begin o.mrd = 1; o.adr = 1; end
      4'd4:  begin o.rw = 1; o.res = 2'b01; o.ret = 1; end
      4'd5:  begin o.mwr = 1; o.adr = 1; o.ret = re; end
      4'd6:  begin o.a = 2'b10; o.aop = 2'b10; end
      4'd7:  begin o.rw = 1; o.ret = 1; end
      4'd8:  begin o.a = 2'b10; o.b = 2'b01; o.aop = 2'b10; end
      4'd9:  begin o.pcu = 1; o.a = 2'b01; o.b = 2'b10; end
      4'd10: begin o.br = 1; o.a = 2'b10; o.aop = 2'b01; o.ret = 1; end
      4'd11: begin o.a = 2'b10; o.b = 2'b01; end
      4'd12: begin o.pcu = 1; o.a = 2'b01; o.b = 2'b10; end
      4'd13: begin o.a = 2'b11; o.b = 2'b01; end
      4'd14: begin o.a = 2'b01; o.b = 2'b01; end
      default: o.hlt = 1;
    endcase
    if (!v.rst) {o.pcu, o.br, o.mrd, o.mwr, o.irw, o.rw, o.ret} = '0;
    return o;
  endfunction

  function automatic vec_t mk(input int d, input logic r, input logic [6:0] o, input logic [2:0] f,
                              input logic y, input logic [3:0] s, input logic il, input string n);
    vec_t v;
    v.dut = d; v.rst = r; v.op = o; v.f3 = f; v.rdy = y; v.st = s; v.ill = il; v.nm = n;
    return v;
  endfunction

  task automatic add(input int d, input logic r, input logic [6:0] o, input logic [2:0] f,
                     input logic y, input logic [3:0] s, input logic il, input string n);
    vecs.push_back(mk(d, r, o, f, y, s, il, n));
  endtask

  task automatic chk(input string nm, input int d, input obs_t e);
    nvec++;
    if (obs[d] !== e) begin
      nbad++;
      $display("FAIL %s dut%0d: got %h (state %0d) want %h (state %0d)", nm, d, obs[d], obs[d].st, e, e.st);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, e.dut, e.exp);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t s;
    rst = 1'b0; op = '0; f3 = '0; rdy = 1'b0;

    add(0, 0, RR, 0, 1, 0, 0, "rst0");
    // LW with two wait cycles in FETCH and MEMREAD: 9 cycles, single IRWrite
    add(0, 1, LW, 2, 0, 0, 0, "lw_f0");   add(0, 1, LW, 2, 0, 0, 0, "lw_f1");
    add(0, 1, LW, 2, 1, 0, 0, "lw_f2");   add(0, 1, LW, 2, 0, 1, 0, "lw_dec");
    add(0, 1, LW, 2, 0, 2, 0, "lw_adr");  add(0, 1, LW, 2, 0, 3, 0, "lw_rd0");
    add(0, 1, LW, 2, 0, 3, 0, "lw_rd1");  add(0, 1, LW, 2, 1, 3, 0, "lw_rd2");
    add(0, 1, LW, 2, 0, 4, 0, "lw_wb");
    // SW with one wait in MEMWRITE: retire only in the completing cycle
    add(0, 1, SW, 2, 1, 0, 0, "sw_f");    add(0, 1, SW, 2, 1, 1, 0, "sw_dec");
    add(0, 1, SW, 2, 1, 2, 0, "sw_adr");  add(0, 1, SW, 2, 0, 5, 0, "sw_wr0");
    add(0, 1, SW, 2, 1, 5, 0, "sw_wr1");
    add(0, 1, RR, 0, 1, 0, 0, "r_f");     add(0, 1, RR, 0, 0, 1, 0, "r_dec");
    add(0, 1, RR, 0, 0, 6, 0, "r_ex");    add(0, 1, RR, 0, 0, 7, 0, "r_wb");
    add(0, 1, II, 0, 1, 0, 0, "i_f");     add(0, 1, II, 0, 1, 1, 0, "i_dec");
    add(0, 1, II, 0, 1, 8, 0, "i_ex");    add(0, 1, II, 0, 1, 7, 0, "i_wb");
    add(0, 1, JAL, 0, 1, 0, 0, "jal_f");  add(0, 1, JAL, 0, 1, 1, 0, "jal_dec");
    add(0, 1, JAL, 0, 1, 9, 0, "jal_x");  add(0, 1, JAL, 0, 1, 7, 0, "jal_wb");
    add(0, 1, JALR, 0, 1, 0, 0, "jalr_f");  add(0, 1, JALR, 0, 1, 1, 0, "jalr_dec");
    add(0, 1, JALR, 0, 1, 11, 0, "jalr_a"); add(0, 1, JALR, 0, 1, 12, 0, "jalr_x");
    add(0, 1, JALR, 0, 1, 7, 0, "jalr_wb");
    add(0, 1, BR, 5, 1, 0, 0, "bge_f");   add(0, 1, BR, 5, 1, 1, 0, "bge_dec");
    add(0, 1, BR, 5, 1, 10, 0, "bge_br");
    add(0, 1, BR, 0, 1, 0, 0, "beq_f");   add(0, 1, BR, 0, 1, 1, 0, "beq_dec");
    add(0, 1, BR, 0, 1, 10, 0, "beq_br");
    add(0, 1, LUI, 0, 1, 0, 0, "lui_f");  add(0, 1, LUI, 0, 1, 1, 0, "lui_dec");
    add(0, 1, LUI, 0, 1, 13, 0, "lui_x"); add(0, 1, LUI, 0, 1, 7, 0, "lui_wb");
    add(0, 1, AUIPC, 0, 1, 0, 0, "aui_f");  add(0, 1, AUIPC, 0, 1, 1, 0, "aui_dec");
    add(0, 1, AUIPC, 0, 1, 14, 0, "aui_x"); add(0, 1, AUIPC, 0, 1, 7, 0, "aui_wb");
    // illegal branch funct3 -> sticky HALT regardless of mem_ready or op
    add(0, 1, BR, 2, 1, 0, 0, "bill_f");  add(0, 1, BR, 2, 1, 1, 0, "bill_dec");
    add(0, 1, BR, 2, 1, 15, 1, "halt0");  add(0, 1, BR, 2, 1, 15, 1, "halt1");
    add(0, 1, RR, 0, 0, 15, 1, "halt2");
    add(0, 0, RR, 0, 1, 0, 0, "rst1");
    // HALT_ON_ILL=0: illegal returns to FETCH, flag stays, next instruction runs
    add(1, 1, BAD, 0, 1, 0, 0, "nh_f");   add(1, 1, BAD, 0, 1, 1, 0, "nh_dec");
    add(1, 1, BAD, 0, 1, 0, 1, "nh_ret"); add(1, 1, RR, 0, 1, 1, 1, "nh_rdec");
    add(1, 1, RR, 0, 1, 6, 1, "nh_rex");  add(1, 1, RR, 0, 1, 7, 1, "nh_rwb");
    add(1, 1, RR, 0, 1, 0, 1, "nh_f2");   add(1, 1, BR, 3, 1, 1, 1, "nh_bdec");
    add(1, 1, BR, 3, 1, 0, 1, "nh_bret");
    add(0, 0, RR, 0, 1, 0, 0, "rst2");
    // MEM_WAIT=0 ignores mem_ready; SUPPORT_UPPER=0 makes LUI illegal
    add(2, 1, LW, 2, 0, 0, 0, "nw_f");    add(2, 1, LW, 2, 0, 1, 0, "nw_dec");
    add(2, 1, LW, 2, 0, 2, 0, "nw_adr");  add(2, 1, LW, 2, 0, 3, 0, "nw_rd");
    add(2, 1, LW, 2, 0, 4, 0, "nw_wb");
    add(2, 1, LUI, 0, 0, 0, 0, "nu_f");   add(2, 1, LUI, 0, 0, 1, 0, "nu_dec");
    add(2, 1, LUI, 0, 0, 15, 1, "nu_halt");

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; op = vecs[i].op; f3 = vecs[i].f3; rdy = vecs[i].rdy;
      s.dut = vecs[i].dut; s.exp = expect_of(vecs[i]); s.nm = vecs[i].nm;
      sb.push_back(s);
    end
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end

    // Reset dropped in the middle of an R-type EXEC_R cycle
    @(posedge clk); #1; rst = 1'b0; op = RR; f3 = 3'd0; rdy = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t1_exec_r", 0, expect_of(mk(0, 1, RR, 0, 1, 6, 0, "")));
    #2 rst = 1'b0;
    #1 chk("t1_rst_mid", 0, expect_of(mk(0, 0, RR, 0, 1, 0, 0, "")));
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("t1_release", 0, expect_of(mk(0, 1, RR, 0, 1, 0, 0, "")));
    chk("t1_ill_clr", 2, expect_of(mk(2, 1, RR, 0, 1, 0, 0, "")));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
